spi_slave_rx_tx: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) target that sits at the far end of the MCU's SPI master lines (mosi, miso, ss, sck).
- Used on the FPGA test fixture to capture words the core transmits and to return a programmable reply word.
- Samples all SPI inputs with the system clock; no logic runs in the sck domain.
- Presents received words through a valid/ack handshake, with sticky overflow detection.

---
 rtl/spi_slave_rx_tx.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 target: oversamples sck/ss/mosi with clk, captures MOSI words into a
// valid/ack register with sticky overflow, and shifts a programmable reply word out on MISO.
module spi_slave_rx_tx #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q, sync_valid_q;
  logic                   sck_hist_q, ss_hist_q, armed_q;
  logic                   sck_sync, ss_sync, mosi_sync;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;

  assign sck_sync  = sck_sync_q[SYNC_STAGES-1];
  assign ss_sync   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q   <= '0;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sync_valid_q <= '0;
      sck_hist_q   <= 1'b0;
      ss_hist_q    <= 1'b1;
      armed_q      <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sync_valid_q <= {sync_valid_q[SYNC_STAGES-2:0], 1'b1};
      sck_hist_q   <= sck_sync;
      ss_hist_q    <= ss_sync;
      // Only a genuine deselect seen after reset arms frame detection, so a frame
      // already running when reset is released is ignored.
      armed_q      <= armed_q | (sync_valid_q[SYNC_STAGES-1] & ss_sync);
    end
  end

  assign sck_rise = sck_sync & ~sck_hist_q;
  assign sck_fall = ~sck_sync & sck_hist_q;
  assign ss_rise  = ss_sync & ~ss_hist_q;
  assign ss_fall  = ~ss_sync & ss_hist_q & armed_q;

  // Transfer state
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  miso_q, miso_d;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] next_word;

  assign next_word = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    count_d    = count_q;
    word_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          tx_shift_d = tx_buf_q;
          rx_shift_d = '0;
          count_d    = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        // Deselect takes priority over a coincident sck rise; partial words are dropped.
        if (ss_rise) begin
          state_d = StIdle;
          count_d = '0;
        end else if (sck_rise) begin
          rx_shift_d = next_word;
          if (count_q == CntW'(DATA_WIDTH - 1)) begin
            word_done  = 1'b1;
            count_d    = '0;
            tx_shift_d = tx_buf_q;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end else if (sck_fall && count_q != '0) begin
          tx_shift_d = tx_shift_q << 1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_buf_d   = tx_wr ? tx_data : tx_buf_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovf_d      = ovf_q;

    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    // A completing word beats both the ack and ovf_clr.
    if (word_done) begin
      rx_data_d  = next_word;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) begin
        ovf_d = 1'b1;
      end
    end

    miso_d = (state_d == StXfer) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      count_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
      miso_q     <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == StXfer);

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: a mode-0 master at sck = clk/16 with a scoreboard
// of expected received words and expected MISO replies.
module tb_spi_slave_rx_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = '0;
  logic       tx_wr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];

  spi_slave_rx_tx #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .ss      (ss),
    .mosi    (mosi),
    .miso    (miso),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ack  (rx_ack),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic write_reply(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    tick(1);
    tx_wr   = 1'b0;
  endtask

  task automatic frame_start();
    ss = 1'b0;
    tick(8);
    check("busy_in_frame", busy, 1);
  endtask

  task automatic frame_end();
    tick(8);
    ss = 1'b1;
    tick(8);
    check("busy_after_frame", busy, 0);
  endtask

  // Master shifts nbits of w MSB first; optional rx_ack in the word-completion detect cycle.
  task automatic xfer(input logic [7:0] w, input logic [7:0] reply, input int nbits,
                      input bit ack_at_done);
    logic [7:0] got;
    got = '0;
    if (nbits == 8) begin
      rx_q.push_back(w);
      miso_q.push_back(reply);
    end
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = w[i];
      tick(8);
      sck    = 1'b1;
      got[i] = miso;
      if (ack_at_done && i == 0) begin
        tick(2);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(5);
      end else begin
        tick(8);
      end
      sck = 1'b0;
    end
    if (nbits == 8) check("miso_word", got, miso_q.pop_front());
  endtask

  task automatic expect_word(input bit ack);
    int k;
    k = 0;
    while (!rx_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("rx_valid_set", rx_valid, 1);
    check("rx_data", rx_data, rx_q.pop_front());
    if (ack) begin
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
      check("rx_valid_clr", rx_valid, 0);
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    tick(3);
    rst = 1'b0;
    tick(5);

    // 1: single word with reply 0x3C
    write_reply(8'h3C);
    frame_start();
    xfer(8'hA5, 8'h3C, 8, 1'b0);
    frame_end();
    expect_word(1'b1);

    // 2: back-to-back words with ack after each
    frame_start();
    xfer(8'h12, 8'h3C, 8, 1'b0);
    expect_word(1'b1);
    xfer(8'h34, 8'h3C, 8, 1'b0);
    expect_word(1'b1);
    frame_end();
    check("t2_ovf", ovf, 0);

    // 3: overflow, then clear
    frame_start();
    xfer(8'h55, 8'h3C, 8, 1'b0);
    xfer(8'hAA, 8'h3C, 8, 1'b0);
    frame_end();
    void'(rx_q.pop_front());
    check("t3_ovf_set", ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t3_ovf_clr", ovf, 0);
    check("t3_valid_held", rx_valid, 1);
    expect_word(1'b1);

    // 4: aborted partial word, then a full frame
    frame_start();
    xfer(8'hFF, 8'h00, 5, 1'b0);
    frame_end();
    check("t4_no_valid", rx_valid, 0);
    check("t4_rx_data_kept", rx_data, 8'hAA);
    frame_start();
    xfer(8'h81, 8'h3C, 8, 1'b0);
    frame_end();
    expect_word(1'b0);

    // 5: reset mid-word, frame in progress ignored, then reception with cleared tx_buf
    frame_start();
    xfer(8'h0F, 8'h00, 3, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_miso", miso, 0);
    check("t5_rx_data", rx_data, 0);
    check("t5_rx_valid", rx_valid, 0);
    check("t5_ovf", ovf, 0);
    check("t5_busy", busy, 0);
    tick(2);
    rst = 1'b0;
    tick(10);
    check("t5_stale_frame_ignored", busy, 0);
    ss = 1'b1;
    tick(8);
    frame_start();
    xfer(8'hC3, 8'h00, 8, 1'b0);
    frame_end();
    expect_word(1'b1);

    // 6: rx_ack coincides with completion of a new word
    write_reply(8'h96);
    frame_start();
    xfer(8'h5A, 8'h96, 8, 1'b0);
    expect_word(1'b0);
    xfer(8'h7E, 8'h96, 8, 1'b1);
    check("t6_ovf", ovf, 0);
    expect_word(1'b1);
    frame_end();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
